// File: rtl/dmem_line_responder.sv
// -----------------------------------------------------------------------------
// dmem_line_responder
//   Line-granular data memory that answers the data cache's memory requests.
//   Each request moves one 256-bit (32-byte) line and completes with a single
//   one-cycle acknowledge pulse a fixed LATENCY cycles after the request was
//   sampled.
//
// Handshake: the requester raises enable_i with write_i/addr_i/data_i stable
//   and holds enable_i until ack_o. Request fields are captured only at an
//   IDLE edge; afterwards enable_i and the fields are ignored until the
//   transaction finishes. A dropped enable_i does not abort it. ack_o is high
//   in exactly one cycle, and for a read data_o carries the line in that cycle.
//   data_o then holds its value until the next read completes.
//
// Parameters:
//   LATENCY     cycles from the request-sampling edge to the ack cycle (>= 1)
//   LINE_ADDR_W line-index width; memory holds 2**LINE_ADDR_W lines
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous reset, active high
//   enable_i  request valid
//   write_i   1 = line write, 0 = line read
//   addr_i    byte address; line index = addr_i[LINE_ADDR_W+4:5]
//   data_i    write line data
//   ack_o     one-cycle completion pulse (registered)
//   data_o    read line data (registered)
//   rd_cnt_o  completed reads, saturating     (only with DMEM_STATS_EN)
//   wr_cnt_o  completed writes, saturating    (only with DMEM_STATS_EN)
//
// Optional feature macro: DMEM_STATS_EN adds the read/write statistics
//   counters and their ports.
//
// The FSM state is held in state_q (IDLE/WAIT/ACK) for hierarchical probing.
// -----------------------------------------------------------------------------
module dmem_line_responder #(
    parameter int LATENCY     = 10,
    parameter int LINE_ADDR_W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]  rd_cnt_o,
    output logic [31:0]  wr_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam int DEPTH = 1 << LINE_ADDR_W;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LINE_ADDR_W-1:0] idx_q, idx_d;
    logic                   write_q, write_d;
    logic [255:0]           wdata_q, wdata_d;
    logic                   ack_q, ack_d;
    logic [255:0]           rdata_q;

    logic [255:0]           mem_q [DEPTH];

    // Access port of the memory array, driven in the cycle whose closing edge
    // enters ACK.
    logic                   mem_we;
    logic                   mem_re;
    logic [LINE_ADDR_W-1:0] acc_idx;
    logic [255:0]           acc_wdata;

    logic [LINE_ADDR_W-1:0] addr_idx;
    logic                   unused_addr_bits;

    // Offset bits and bits above the line index are dropped, so addresses
    // beyond the array wrap onto it.
    assign addr_idx         = addr_i[LINE_ADDR_W+4:5];
    assign unused_addr_bits = ^{addr_i[31:LINE_ADDR_W+5], addr_i[4:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        ack_d     = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_idx;
                    write_d = write_i;
                    wdata_d = data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // No wait cycles: the access happens on the sampling
                        // edge itself, straight from the request inputs.
                        state_d   = ST_ACK;
                        ack_d     = 1'b1;
                        acc_idx   = addr_idx;
                        acc_wdata = data_i;
                        mem_we    = write_i;
                        mem_re    = ~write_i;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    mem_we  = write_q;
                    mem_re  = ~write_q;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            if (mem_re) begin
                rdata_q <= mem_q[acc_idx];
            end
        end
    end

    // Array contents survive reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (mem_re && (rd_cnt_q != 32'hFFFF_FFFF)) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (mem_we && (wr_cnt_q != 32'hFFFF_FFFF)) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_line_responder.sv
module tb_dmem_line_responder;

    localparam int LAT = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT with default latency
    logic         en, wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         ack;
    logic [255:0] rdata;
    // DUT with latency 1
    logic         en1, wr1;
    logic [31:0]  addr1;
    logic [255:0] wdata1;
    logic         ack1;
    logic [255:0] rdata1;
`ifdef DMEM_STATS_EN
    logic [31:0]  rd_cnt, wr_cnt, rd_cnt1, wr_cnt1;
`endif

    dmem_line_responder #(.LATENCY(LAT), .LINE_ADDR_W(9)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (en),
        .write_i  (wr),
        .addr_i   (addr),
        .data_i   (wdata),
        .ack_o    (ack),
        .data_o   (rdata)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt_o (rd_cnt),
        .wr_cnt_o (wr_cnt)
`endif
    );

    dmem_line_responder #(.LATENCY(1), .LINE_ADDR_W(9)) dut1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (en1),
        .write_i  (wr1),
        .addr_i   (addr1),
        .data_i   (wdata1),
        .ack_o    (ack1),
        .data_o   (rdata1)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt_o (rd_cnt1),
        .wr_cnt_o (wr_cnt1)
`endif
    );

    // ---------------- reference model / scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [255:0] mem0 [int];
    logic [255:0] mem1 [int];
    logic [255:0] last0, last1;
    logic [255:0] exp_q [$];
    int nrd, nwr;

    // 32-byte lines, 512 lines: everything else in the address wraps.
    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % 512);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- driver ----------------
    // Fields are applied at a negedge; the next posedge is the sampling edge.
    // hold: leave enable_i high after the ack (writeback->refill style).
    // drop: release enable_i one cycle into the wait.
    task automatic run_txn(input bit one, input bit w, input logic [31:0] a,
                           input logic [255:0] d, input bit hold, input bit drop);
        int cyc;
        int li;
        int exp_lat;
        bit seen;
        logic [255:0] expd;
        logic [255:0] obs;
        li      = line_of(a);
        exp_lat = one ? 1 : LAT;
        if (!w) exp_q.push_back(one ? mem1[li] : mem0[li]);
        if (one) begin en1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
        else     begin en  = 1'b1; wr  = w; addr  = a; wdata  = d; end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (one ? ack1 : ack) begin
                seen = 1'b1;
            end else if (!one) begin
                // request fields must be ignored while the access is in flight
                if (drop) en = 1'b0;
                wr    = 1'($urandom);
                addr  = $urandom;
                wdata = rand_line();
            end
        end
        checks++;
        if (!seen || cyc != exp_lat) begin
            errors++;
            $display("FAIL latency(dut%0d): ack after %0d cycles (seen=%0d), expected %0d",
                     one, cyc, seen, exp_lat);
        end
        obs = one ? rdata1 : rdata;
        if (!w) begin
            expd = exp_q.pop_front();
            checks++;
            if (obs !== expd) begin
                errors++;
                $display("FAIL read_data(dut%0d) addr=%h: got %h expected %h", one, a, obs, expd);
            end
            if (one) last1 = expd; else last0 = expd;
            if (!one) nrd++;
        end else begin
            expd = one ? last1 : last0;
            checks++;
            if (obs !== expd) begin
                errors++;
                $display("FAIL write_keeps_data_o(dut%0d): got %h expected %h", one, obs, expd);
            end
            if (one) mem1[li] = d; else mem0[li] = d;
            if (!one) nwr++;
        end
        if (!hold) begin
            if (one) en1 = 1'b0; else en = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ((one ? ack1 : ack) !== 1'b0) begin
            errors++;
            $display("FAIL ack_width(dut%0d): ack still %b one cycle later, expected 0", one, one ? ack1 : ack);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_cycles(3);
        checks += 4;
        if (ack !== 1'b0)   begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        if (rdata !== '0)   begin errors++; $display("FAIL reset_data: got %h expected 0", rdata); end
        if (ack1 !== 1'b0)  begin errors++; $display("FAIL reset_ack1: got %b expected 0", ack1); end
        if (rdata1 !== '0)  begin errors++; $display("FAIL reset_data1: got %h expected 0", rdata1); end
`ifdef DMEM_STATS_EN
        checks++;
        if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_stats: rd=%0d wr=%0d expected 0/0", rd_cnt, wr_cnt);
        end
`endif
        rst   = 1'b0;
        last0 = '0;
        last1 = '0;
        nrd   = 0;
        nwr   = 0;
        idle_cycles(1);
    endtask

    task automatic test_write_read();
        logic [255:0] a5;
        a5 = {32{8'hA5}};
        run_txn(1'b0, 1'b1, 32'h0000_0040, a5, 1'b0, 1'b0);
        idle_cycles(1);
        run_txn(1'b0, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_latency_one();
        logic [255:0] d;
        d = rand_line();
        run_txn(1'b1, 1'b1, 32'h0000_0120, d, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 32'h0000_0120, '0, 1'b0, 1'b0);
        // back-to-back at minimum spacing (enable held through the ack)
        run_txn(1'b1, 1'b1, 32'h0000_0140, rand_line(), 1'b1, 1'b0);
        run_txn(1'b1, 1'b0, 32'h0000_0140, '0, 1'b0, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        logic [255:0] d11;
        d11 = {32{8'h11}};
        run_txn(1'b0, 1'b1, 32'h0000_0200, rand_line(), 1'b0, 1'b0);
        idle_cycles(1);
        // writeback with enable held, then refill read of another line
        run_txn(1'b0, 1'b1, 32'h0000_0100, d11, 1'b1, 1'b0);
        run_txn(1'b0, 1'b0, 32'h0000_0200, '0, 1'b0, 1'b0);
        idle_cycles(1);
        run_txn(1'b0, 1'b0, 32'h0000_0100, '0, 1'b0, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_reset_abort();
        bit saw_ack;
        run_txn(1'b0, 1'b1, 32'h0000_0300, rand_line(), 1'b0, 1'b0);
        idle_cycles(1);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0300; wdata = rand_line();
        saw_ack = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        checks += 2;
        if (saw_ack) begin errors++; $display("FAIL abort_ack: ack observed=1 expected 0"); end
        if (rdata !== '0) begin errors++; $display("FAIL abort_data: got %h expected 0", rdata); end
`ifdef DMEM_STATS_EN
        checks++;
        if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
            errors++; $display("FAIL abort_stats: rd=%0d wr=%0d expected 0/0", rd_cnt, wr_cnt);
        end
`endif
        last0 = '0;
        last1 = '0;
        nrd   = 0;
        nwr   = 0;
        // the dropped write must not have reached the array
        run_txn(1'b0, 1'b0, 32'h0000_0300, '0, 1'b0, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_alias_drop();
        run_txn(1'b0, 1'b1, 32'h0000_0040, rand_line(), 1'b0, 1'b0);
        idle_cycles(1);
        run_txn(1'b0, 1'b0, 32'h8000_0040, '0, 1'b0, 1'b1);
        idle_cycles(1);
        run_txn(1'b0, 1'b1, 32'hFFFF_C05F, rand_line(), 1'b0, 1'b1);
        run_txn(1'b0, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit w;
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            // keep a few lines hot so reads hit previously written data
            if ($urandom_range(0, 1)) a = {$urandom_range(0, 7), 5'(n)} + (32'($urandom_range(0, 3)) << 14);
            w = 1'($urandom_range(0, 1));
            if (!mem0.exists(line_of(a))) w = 1'b1;
            run_txn(1'b0, w, a, rand_line(), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end
        en = 1'b0;
        idle_cycles(2);
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        checks += 2;
        if (rd_cnt !== 32'(nrd)) begin errors++; $display("FAIL rd_cnt: got %0d expected %0d", rd_cnt, nrd); end
        if (wr_cnt !== 32'(nwr)) begin errors++; $display("FAIL wr_cnt: got %0d expected %0d", wr_cnt, nwr); end
        test_reset();
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        rst = 1'b1;
        en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        en1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        last0 = '0; last1 = '0; nrd = 0; nwr = 0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_latency_one();
        test_back_to_back();
        test_reset_abort();
        test_alias_drop();
        test_random();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
